// File: rtl/fetch_predict_stage.sv
// fetch_predict_stage: fetch PC register, direct-mapped BTB prediction and the decode-side pipeline register.
// Execute feeds back misprediction redirects and resolution updates that train the BTB.
module fetch_predict_stage #(
    parameter int              size        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [size-1:0] RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            misprediction_i,
    input  logic [size-1:0] correct_pc_i,
    input  logic            update_valid_i,
    input  logic [size-1:0] update_pc_i,
    input  logic [size-1:0] update_target_i,
    input  logic            update_taken_i,
    output logic [size-1:0] imem_addr_o,
    output logic [size-1:0] pc_o,
    output logic [size-1:0] pc_plus_o,
    output logic            branch_prediction_o,
    output logic            valid_o
);
    localparam int IDX = $clog2(BTB_ENTRIES);
    localparam int TW  = size - IDX - 2;

    logic [size-1:0] pc_q, pc_d, pc_out_q, pc_out_d, pc_plus_q, pc_plus_d, pc_inc, next_pc;
    logic            pred_q, pred_d, valid_q, valid_d, hit, pred, adv;
    logic            btb_v_q   [BTB_ENTRIES];
    logic [TW-1:0]   btb_tag_q [BTB_ENTRIES];
    logic [size-1:0] btb_tgt_q [BTB_ENTRIES];
    logic [1:0]      btb_ctr_q [BTB_ENTRIES];
    logic [IDX-1:0]  f_idx, u_idx;
    logic [TW-1:0]   f_tag, u_tag;
    logic            u_hit;
    logic [1:0]      u_ctr;
    logic            unused_lo;

    always_comb begin
        f_idx     = pc_q[IDX+1:2];
        f_tag     = pc_q[size-1:IDX+2];
        hit       = btb_v_q[f_idx] && (btb_tag_q[f_idx] == f_tag);
        pred      = hit && btb_ctr_q[f_idx][1];
        pc_inc    = pc_q + size'(4);
        next_pc   = pred ? btb_tgt_q[f_idx] : pc_inc;
        adv       = !misprediction_i && !stall_i;
        pc_d      = misprediction_i ? correct_pc_i : (stall_i ? pc_q : next_pc);
        pc_out_d  = adv ? pc_q : pc_out_q;
        pc_plus_d = adv ? pc_inc : pc_plus_q;
        pred_d    = misprediction_i ? 1'b0 : (stall_i ? pred_q : pred);
        valid_d   = misprediction_i ? 1'b0 : (stall_i ? valid_q : 1'b1);
        u_idx     = update_pc_i[IDX+1:2];
        u_tag     = update_pc_i[size-1:IDX+2];
        u_hit     = btb_v_q[u_idx] && (btb_tag_q[u_idx] == u_tag);
        u_ctr     = update_taken_i ? ((btb_ctr_q[u_idx] == 2'd3) ? 2'd3 : btb_ctr_q[u_idx] + 2'd1)
                                   : ((btb_ctr_q[u_idx] == 2'd0) ? 2'd0 : btb_ctr_q[u_idx] - 2'd1);
        unused_lo = ^update_pc_i[1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            pc_out_q  <= '0;
            pc_plus_q <= '0;
            pred_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            pc_out_q  <= pc_out_d;
            pc_plus_q <= pc_plus_d;
            pred_q    <= pred_d;
            valid_q   <= valid_d;
        end
    end

    // Training is written after lookup, so a same-index lookup sees pre-update contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_v_q[i]   <= 1'b0;
                btb_tag_q[i] <= '0;
                btb_tgt_q[i] <= '0;
                btb_ctr_q[i] <= 2'b01;
            end
        end else if (update_valid_i) begin
            if (u_hit) begin
                btb_ctr_q[u_idx] <= u_ctr;
                if (update_taken_i) btb_tgt_q[u_idx] <= update_target_i;
            end else if (update_taken_i) begin
                btb_v_q[u_idx]   <= 1'b1;
                btb_tag_q[u_idx] <= u_tag;
                btb_tgt_q[u_idx] <= update_target_i;
                btb_ctr_q[u_idx] <= 2'b10;
            end
        end
    end

    assign imem_addr_o         = pc_q;
    assign pc_o                = pc_out_q;
    assign pc_plus_o           = pc_plus_q;
    assign branch_prediction_o = pred_q;
    assign valid_o             = valid_q;
endmodule

// File: tb/tb_fetch_predict_stage.sv
// tb_fetch_predict_stage: directed test-plan scenarios plus randomized traffic against a behavioural model.
module tb_fetch_predict_stage;
    localparam int N = 16;
    localparam logic [31:0] RST_PC = 32'h100;

    logic        clk = 1'b0, reset = 1'b0, stall_i = 1'b0, misprediction_i = 1'b0;
    logic        update_valid_i = 1'b0, update_taken_i = 1'b0;
    logic [31:0] correct_pc_i = '0, update_pc_i = '0, update_target_i = '0;
    logic [31:0] imem_addr_o, pc_o, pc_plus_o;
    logic        branch_prediction_o, valid_o;

    int checks = 0, errors = 0;

    // Model state: fetch PC, decode slot, and BTB as plain arrays.
    logic [31:0] m_pc, m_pco, m_pcp;
    logic        m_pred, m_valid;
    bit          b_v [N];
    logic [31:0] b_tag [N], b_tgt [N];
    int          b_ctr [N];
    logic [31:0] s_imem, s_pco;
    logic        s_pred, s_valid;

    fetch_predict_stage #(.size(32), .BTB_ENTRIES(N), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .misprediction_i(misprediction_i),
        .correct_pc_i(correct_pc_i), .update_valid_i(update_valid_i), .update_pc_i(update_pc_i),
        .update_target_i(update_target_i), .update_taken_i(update_taken_i),
        .imem_addr_o(imem_addr_o), .pc_o(pc_o), .pc_plus_o(pc_plus_o),
        .branch_prediction_o(branch_prediction_o), .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_pco = 0; m_pcp = 0; m_pred = 0; m_valid = 0;
        for (int i = 0; i < N; i++) begin b_v[i] = 0; b_ctr[i] = 1; b_tag[i] = 0; b_tgt[i] = 0; end
    endtask

    task automatic model_edge(input logic mis, input logic [31:0] cpc, input logic st,
                              input logic uv, input logic [31:0] upc, input logic [31:0] utgt, input logic utk);
        int fi, ui;
        logic pr;
        logic [31:0] npc;
        fi  = int'((m_pc / 4) % N);
        pr  = b_v[fi] && b_tag[fi] == (m_pc / (4 * N)) && b_ctr[fi] >= 2;
        npc = pr ? b_tgt[fi] : m_pc + 4;
        if (mis) begin
            m_pc = cpc; m_valid = 0; m_pred = 0;
        end else if (!st) begin
            m_pco = m_pc; m_pcp = m_pc + 4; m_pred = pr; m_valid = 1; m_pc = npc;
        end
        if (uv) begin
            ui = int'((upc / 4) % N);
            if (b_v[ui] && b_tag[ui] == (upc / (4 * N))) begin
                b_ctr[ui] = utk ? ((b_ctr[ui] + 1 > 3) ? 3 : b_ctr[ui] + 1) : ((b_ctr[ui] - 1 < 0) ? 0 : b_ctr[ui] - 1);
                if (utk) b_tgt[ui] = utgt;
            end else if (utk) begin
                b_v[ui] = 1; b_tag[ui] = upc / (4 * N); b_tgt[ui] = utgt; b_ctr[ui] = 2;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".imem"}, imem_addr_o, m_pc);
        check({tag, ".pc"}, pc_o, m_pco);
        check({tag, ".pcp"}, pc_plus_o, m_pcp);
        check({tag, ".pred"}, {31'b0, branch_prediction_o}, {31'b0, m_pred});
        check({tag, ".valid"}, {31'b0, valid_o}, {31'b0, m_valid});
    endtask

    task automatic step(input string tag, input logic mis, input logic [31:0] cpc, input logic st,
                        input logic uv, input logic [31:0] upc, input logic [31:0] utgt, input logic utk);
        misprediction_i = mis; correct_pc_i = cpc; stall_i = st;
        update_valid_i = uv; update_pc_i = upc; update_target_i = utgt; update_taken_i = utk;
        @(posedge clk);
        model_edge(mis, cpc, st, uv, upc, utgt, utk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1;
        #1;
        model_reset();
        check("rst.imem", imem_addr_o, RST_PC);
        check("rst.valid", {31'b0, valid_o}, 32'd0);
        check("rst.pc", pc_o, 32'd0);
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        model_reset();
        do_reset();
        // Sequential fetch from an empty BTB.
        idle("seq0");
        check("seq0.valid_const", {31'b0, valid_o}, 32'd1);
        idle("seq1");
        idle("seq2");
        check("seq2.imem_const", imem_addr_o, 32'h10C);
        check("seq2.pc_const", pc_o, 32'h108);
        // Train 0x108 taken, then redirect fetch back to it.
        step("train", 0, 0, 0, 1, 32'h108, 32'h200, 1);
        step("redir", 1, 32'h108, 0, 0, 0, 0, 0);
        idle("hit");
        check("hit.pred_const", {31'b0, branch_prediction_o}, 32'd1);
        check("hit.pc_const", pc_o, 32'h108);
        check("hit.imem_const", imem_addr_o, 32'h200);
        // Not-taken training: 2 -> 1 -> 0 -> 0.
        step("nt0", 0, 0, 1, 1, 32'h108, 0, 0);
        step("redir2", 1, 32'h108, 0, 0, 0, 0, 0);
        idle("nt_look");
        check("nt_look.pred_const", {31'b0, branch_prediction_o}, 32'd0);
        step("nt1", 0, 0, 1, 1, 32'h108, 0, 0);
        step("nt2", 0, 0, 1, 1, 32'h108, 0, 0);
        check("nt2.ctr_model", 32'(b_ctr[2]), 32'd0);
        // Mispredict while stalled.
        s_pco = pc_o;
        step("mis_st", 1, 32'h300, 1, 0, 0, 0, 0);
        check("mis_st.imem_const", imem_addr_o, 32'h300);
        check("mis_st.valid_const", {31'b0, valid_o}, 32'd0);
        check("mis_st.pc_hold", pc_o, s_pco);
        idle("after_mis");
        check("after_mis.pc_const", pc_o, 32'h300);
        // Three-cycle stall holds everything.
        idle("pre_st");
        s_imem = imem_addr_o; s_pco = pc_o; s_pred = branch_prediction_o; s_valid = valid_o;
        for (int i = 0; i < 3; i++) begin
            step("stall", 0, 0, 1, 0, 0, 0, 0);
            check("stall.imem_hold", imem_addr_o, s_imem);
            check("stall.pc_hold", pc_o, s_pco);
            check("stall.pred_hold", {31'b0, branch_prediction_o}, {31'b0, s_pred});
            check("stall.valid_hold", {31'b0, valid_o}, {31'b0, s_valid});
        end
        idle("resume");
        check("resume.pc_next", pc_o, s_imem);
        // Retrain 0x108 taken, then reset mid-stream.
        step("train2", 0, 0, 0, 1, 32'h108, 32'h200, 1);
        step("train3", 0, 0, 0, 1, 32'h108, 32'h200, 1);
        #2;
        do_reset();
        idle("post0");
        idle("post1");
        idle("post2");
        check("post2.pc_const", pc_o, 32'h108);
        check("post2.pred_const", {31'b0, branch_prediction_o}, 32'd0);
        // PC wrap.
        step("wrap_redir", 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        idle("wrap");
        check("wrap.imem_const", imem_addr_o, 32'h0);
        check("wrap.pcp_const", pc_plus_o, 32'h0);
        // Randomized traffic over a small address pool so hits, aliasing and saturation all occur.
        for (int n = 0; n < 600; n++) begin
            logic mis, st, uv, tk;
            logic [31:0] cpc, upc, tgt;
            mis = ($urandom_range(0, 9) == 0);
            st  = ($urandom_range(0, 4) == 0);
            uv  = ($urandom_range(0, 2) != 0);
            tk  = $urandom_range(0, 1) == 1;
            cpc = 32'h100 + 4 * $urandom_range(0, 31);
            upc = 32'h100 + 4 * $urandom_range(0, 31) + 32'h40 * $urandom_range(0, 1);
            tgt = 32'h100 + 4 * $urandom_range(0, 31);
            step("rnd", mis, cpc, st, uv, upc, tgt, tk);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
